// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states,
// instruction opcode/funct fields and ALU operation codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// Maps the latched opcode/funct pair to an ALU operation; funct_valid flags
// R-type functions the datapath actually supports.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_select,
  output logic       funct_valid
);

  always_comb begin
    alu_select  = ALU_ADD;
    funct_valid = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        funct_valid = 1'b1;
        case (funct)
          FN_ADD:  alu_select = ALU_ADD;
          FN_AND:  alu_select = ALU_AND;
          FN_OR:   alu_select = ALU_OR;
          FN_XOR:  alu_select = ALU_XOR;
          FN_SLT:  alu_select = ALU_SLT;
          default: funct_valid = 1'b0;
        endcase
      end
      OP_ANDI: alu_select = ALU_AND;
      OP_ORI:  alu_select = ALU_OR;
      // Branch compares operands by XOR; the datapath raises zero on equality.
      OP_BEQ:  alu_select = ALU_XOR;
      default: alu_select = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute states,
// drives datapath selects and write enables, and counts retired instructions.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_select,
  output logic        alu_c_in,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  state_t      state_reg;
  logic [5:0]  opcode_reg;
  logic [5:0]  funct_reg;
  logic [31:0] instr_count_reg;

  logic [2:0]  dec_select;
  logic        funct_valid;
  logic        pc_en;
  logic        ir_en;
  logic        mem_en;
  logic        reg_en;

  alu_decoder u_alu_decoder (
    .opcode      (opcode_reg),
    .funct       (funct_reg),
    .alu_select  (dec_select),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      opcode_reg      <= 6'd0;
      funct_reg       <= 6'd0;
      instr_count_reg <= 32'd0;
    end else begin
      case (state_reg)
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          // The instruction register is stable here; capture it for later states.
          opcode_reg <= opcode;
          funct_reg  <= funct;
          case (opcode)
            OP_LW, OP_SW:             state_reg <= S_MEMADR;
            OP_RTYPE:                 state_reg <= S_EXEC;
            OP_BEQ:                   state_reg <= S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: state_reg <= S_IEXEC;
            OP_J:                     state_reg <= S_JUMP;
            default:                  state_reg <= S_FETCH;
          endcase
        end
        S_MEMADR: state_reg <= (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state_reg <= S_MEMWB;
        S_EXEC:   state_reg <= S_ALUWB;
        S_IEXEC:  state_reg <= S_IWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: begin
          state_reg       <= S_FETCH;
          instr_count_reg <= instr_count_reg + 32'd1;
        end
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    mem_en     = 1'b0;
    reg_en     = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_select = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        ir_en     = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_en     = 1'b1;
      end
      S_MEMWR: begin
        i_or_d = 1'b1;
        mem_en = 1'b1;
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_select = dec_select;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        reg_en  = funct_valid;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_select = dec_select;
        pc_src     = 2'b01;
        pc_en      = zero;
      end
      S_IEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = dec_select;
      end
      S_IWB:  reg_en = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every architectural write, even mid-instruction.
  assign pc_write    = pc_en & ~reset;
  assign ir_write    = ir_en & ~reset;
  assign mem_write   = mem_en & ~reset;
  assign reg_write   = reg_en & ~reset;
  assign alu_c_in    = 1'b0;
  assign state       = state_reg;
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: an instruction-level model predicts every cycle's outputs,
// plus literal state traces and retire counts for selected instructions.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        pc_write, ir_write, mem_write, reg_write;
  logic        i_or_d, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_select;
  logic        alu_c_in;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .i_or_d      (i_or_d),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_select  (alu_select),
    .alu_c_in    (alu_c_in),
    .state       (state),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          st;
    logic        pcw, irw, mw, rw;
    logic        iod, rdst, m2r, srca;
    logic [1:0]  srcb, psrc;
    logic [2:0]  sel;
    bit          sel_dc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          seq_q[$];
  int          checks = 0;
  int          fails = 0;
  string       obs_str;
  logic [31:0] model_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Cycle-by-cycle state walk of one instruction, keyed only on its opcode.
  function automatic void fill_seq(input logic [5:0] op);
    case (op)
      6'b100011: seq_q = {0, 1, 2, 3, 4};
      6'b101011: seq_q = {0, 1, 2, 5};
      6'b000000: seq_q = {0, 1, 6, 7};
      6'b000100: seq_q = {0, 1, 8};
      6'b001000, 6'b001100, 6'b001101: seq_q = {0, 1, 9, 10};
      6'b000010: seq_q = {0, 1, 11};
      default:   seq_q = {0, 1};
    endcase
  endfunction

  function automatic exp_t outs_for(input int st, input logic [5:0] op, input logic [5:0] fn,
                                    input logic z, input logic rst, input logic [31:0] cnt);
    exp_t e;
    e = '{st: st, pcw: 0, irw: 0, mw: 0, rw: 0, iod: 0, rdst: 0, m2r: 0, srca: 0,
          srcb: 2'b00, psrc: 2'b00, sel: 3'b000, sel_dc: 0, cnt: cnt};
    case (st)
      0: begin e.irw = 1; e.pcw = 1; e.srcb = 2'b01; end
      1: e.srcb = 2'b11;
      2: begin e.srca = 1; e.srcb = 2'b10; end
      3: e.iod = 1;
      4: begin e.m2r = 1; e.rw = 1; end
      5: begin e.iod = 1; e.mw = 1; end
      6: begin
        e.srca = 1;
        case (fn)
          6'b100000: e.sel = 3'b000;
          6'b100100: e.sel = 3'b001;
          6'b100101: e.sel = 3'b010;
          6'b100110: e.sel = 3'b011;
          6'b101010: e.sel = 3'b100;
          default:   e.sel_dc = 1;
        endcase
      end
      7: begin
        e.rdst = 1;
        e.rw = (fn == 6'b100000 || fn == 6'b100100 || fn == 6'b100101 ||
                fn == 6'b100110 || fn == 6'b101010);
      end
      8: begin e.srca = 1; e.sel = 3'b011; e.psrc = 2'b01; e.pcw = z; end
      9: begin
        e.srca = 1; e.srcb = 2'b10;
        e.sel = (op == 6'b001100) ? 3'b001 : (op == 6'b001101) ? 3'b010 : 3'b000;
      end
      10: e.rw = 1;
      11: begin e.psrc = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    if (rst) begin e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; end
    return e;
  endfunction

  // Single compare process: checks every cycle the driver has predicted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        obs_str = {obs_str, $sformatf("%h", state)};
        chk("state", 32'(state), 32'(e.st));
        chk("pc_write", 32'(pc_write), 32'(e.pcw));
        chk("ir_write", 32'(ir_write), 32'(e.irw));
        chk("mem_write", 32'(mem_write), 32'(e.mw));
        chk("reg_write", 32'(reg_write), 32'(e.rw));
        chk("i_or_d", 32'(i_or_d), 32'(e.iod));
        chk("reg_dst", 32'(reg_dst), 32'(e.rdst));
        chk("mem_to_reg", 32'(mem_to_reg), 32'(e.m2r));
        chk("alu_src_a", 32'(alu_src_a), 32'(e.srca));
        chk("alu_src_b", 32'(alu_src_b), 32'(e.srcb));
        chk("pc_src", 32'(pc_src), 32'(e.psrc));
        if (!e.sel_dc) chk("alu_select", 32'(alu_select), 32'(e.sel));
        chk("alu_c_in", 32'(alu_c_in), 32'd0);
        chk("instr_count", instr_count, e.cnt);
      end
    end
  end

  // Drive one instruction; abort_at >= 0 asserts reset during that cycle.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int abort_at);
    int n;
    bit aborted;
    fill_seq(op);
    n = seq_q.size();
    obs_str = "";
    aborted = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k <= 1) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      zero  = (seq_q[k] == 8) ? z : 1'($urandom);
      reset = (k == abort_at);
      #1;
      exp_q.push_back(outs_for(seq_q[k], op, fn, z, reset, model_count));
      if (k == abort_at) begin
        model_count = 32'd0;
        aborted = 1;
        break;
      end
    end
    if (!aborted && n > 2) model_count = model_count + 32'd1;
    #2;
    $display("instr op=%b fn=%b zero=%b abort=%0d trace=%s count_model=%0d",
             op, fn, z, abort_at, obs_str, model_count);
  endtask

  // Literal expectations: exact state trace, then FETCH and retire count after.
  task automatic post(input string name, input string trace_lit, input logic [31:0] cnt_lit);
    checks++;
    if (obs_str != trace_lit) begin
      fails++;
      $display("FAIL %s_trace: got %s, expected %s", name, obs_str, trace_lit);
    end
    @(posedge clk);
    #1;
    chk({name, "_next_state"}, 32'(state), 32'd0);
    chk({name, "_count"}, instr_count, cnt_lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    opcode = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    model_count = 32'd0;
    obs_str = "";
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    exp_q.push_back(outs_for(0, 6'd0, 6'd0, 1'b0, 1'b1, 32'd0));
    #2;

    issue(6'b000000, 6'b100000, 1'b0, -1); post("r_add", "0167", 32'd1);
    issue(6'b100011, 6'b000000, 1'b0, -1); post("lw", "01234", 32'd2);
    issue(6'b101011, 6'b000000, 1'b0, -1); post("sw", "0125", 32'd3);
    issue(6'b000000, 6'b100100, 1'b0, -1);
    issue(6'b000000, 6'b100101, 1'b1, -1);
    issue(6'b000000, 6'b100110, 1'b0, -1);
    issue(6'b000000, 6'b101010, 1'b1, -1); post("r_slt", "0167", 32'd7);
    issue(6'b000000, 6'b000001, 1'b0, -1); post("r_bad", "0167", 32'd8);
    issue(6'b000100, 6'b000000, 1'b1, -1); post("beq_taken", "018", 32'd9);
    issue(6'b000100, 6'b000000, 1'b0, -1); post("beq_not", "018", 32'd10);
    issue(6'b001000, 6'b111111, 1'b0, -1);
    issue(6'b001100, 6'b000000, 1'b1, -1);
    issue(6'b001101, 6'b101010, 1'b0, -1); post("ori", "019a", 32'd13);
    issue(6'b111111, 6'b100000, 1'b1, -1); post("illegal", "01", 32'd13);
    issue(6'b100011, 6'b000000, 1'b0, 3);  post("lw_abort", "0123", 32'd0);

    force dut.instr_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_reg;
    model_count = 32'hFFFF_FFFF;
    issue(6'b000010, 6'b000000, 1'b0, -1); post("j_wrap", "01b", 32'd0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  high when the datapath ALU result equals 0.
REQ-007 pc_write, ir_write, mem_write, reg_write  output  1 each  write enables.
REQ-008 i_or_d, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-009 alu_src_b, pc_src  output  2 each  datapath mux selects.
REQ-010 alu_select  output  3  ALU operation; alu_c_in  output  1  ALU carry-in.
REQ-011 state  output  4  current state, for debug.
REQ-012 instr_count  output  32  count of retired instructions.

Function
REQ-013 ALU codes SHALL be: add 000, and 001, or 010, xor 011, slt 100; alu_c_in SHALL always be 0.
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11.
REQ-015 Transitions: FETCH->DECODE; DECODE by latched opcode: lw/sw (100011/101011)->MEMADR, R-type (000000)->EXEC, beq (000100)->BRANCH, addi/andi/ori (001000/001100/001101)->IEXEC, j (000010)->JUMP, any other opcode->FETCH.
REQ-016 MEMADR->MEMRD for lw, ->MEMWR for sw; MEMRD->MEMWB; EXEC->ALUWB; IEXEC->IWB; MEMWB, MEMWR, ALUWB, IWB, BRANCH, JUMP->FETCH; encodings 12-15->FETCH.
REQ-017 opcode and funct SHALL be latched on the DECODE cycle; all later states use the latched copies.
REQ-018 Outputs are decoded from the current state; any signal not listed for a state is 0.
REQ-019 FETCH: ir_write=1, pc_write=1, alu_src_b=01, alu_select=add.
REQ-020 DECODE: alu_src_b=11, alu_select=add (branch target).
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, add. MEMRD: i_or_d=1. MEMWB: mem_to_reg=1, reg_write=1. MEMWR: i_or_d=1, mem_write=1.
REQ-022 EXEC: alu_src_a=1, alu_src_b=00, alu_select from funct: 100000 add, 100100 and, 100101 or, 100110 xor, 101010 slt. ALUWB: reg_dst=1, reg_write=1, unless funct is unsupported, in which case reg_write=0.
REQ-023 IEXEC: alu_src_a=1, alu_src_b=10, alu_select add/and/or for addi/andi/ori. IWB: reg_write=1.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_select=xor, pc_src=01, pc_write=zero (combinational on zero).
REQ-025 JUMP: pc_src=10, pc_write=1.
REQ-026 Latencies: beq and j take 3 cycles; R-type, sw, and I-type ALU instructions take 4 cycles; lw takes 5 cycles; an illegal opcode takes 2 cycles.
REQ-027 instr_count SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, IWB, BRANCH, or JUMP; it SHALL NOT increment for illegal opcodes, and it wraps from 0xFFFFFFFF to 0.

Reset
REQ-028 On a clock edge with reset=1: state=FETCH, latched opcode/funct=0, and instr_count=0.
REQ-029 While reset=1, pc_write, ir_write, mem_write, and reg_write SHALL be forced to 0, including when reset is asserted mid-instruction.
REQ-030 The first cycle after reset deasserts SHALL be a FETCH cycle with enables active.

Structure
REQ-031 State encodings, opcode and funct constants, and ALU select codes SHALL live in the shared package mips_pkg.
REQ-032 The combinational mapping from funct/opcode to alu_select SHALL be the sub-module alu_decoder.

Verification
REQ-033 Apply reset, then opcode=000000 and funct=100000 -> states 0,1,6,7,0; in EXEC alu_select=000; in ALUWB reg_write=1; instr_count=1.
REQ-034 Apply lw (100011) -> states 0,1,2,3,4,0; MEMRD i_or_d=1; MEMWB mem_to_reg=1 and reg_write=1. Apply sw (101011) -> states 0,1,2,5,0 with mem_write=1 in MEMWR.
REQ-035 Apply beq with zero=1 -> pc_write=1 and pc_src=01 in BRANCH. Apply beq with zero=0 -> pc_write=0. Both SHALL use alu_select=011.
REQ-036 Apply opcode=111111 -> states 0,1,0; no write enable is asserted after FETCH; instr_count is unchanged.
REQ-037 Assert reset during MEMRD of lw -> no reg_write occurs, the next state is FETCH, and instr_count=0.
REQ-038 Preload instr_count to 0xFFFFFFFF by force, then retire a j instruction -> instr_count=0 and pc_src=10 in JUMP.
